// File: rtl/anc_audio_tx_pkg.sv
// Shared constants for the ANC audio transmit path (I2S master toward the DAC codec).
package anc_audio_tx_pkg;

    localparam int unsigned AUDIO_DATA_W = 16;
    localparam int unsigned I2S_SLOT_W   = 32;
    localparam int unsigned I2S_CLK_DIV  = 4;

endpackage

// File: rtl/anc_i2s_clkgen.sv
// I2S master timing: BCLK divider, bit/slot counter, LRCK and frame-start strobe.
module anc_i2s_clkgen
    import anc_audio_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = I2S_CLK_DIV,
    parameter int unsigned SLOT_W  = I2S_SLOT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          o_bclk,
    output logic                          o_lrck,
    output logic                          o_fall_stb,
    output logic                          o_frame_start,
    output logic [$clog2(2*SLOT_W)-1:0]   o_bit_nxt
);

    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam int unsigned BW = $clog2(2*SLOT_W);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2*SLOT_W - 1);
    localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_W);

    logic [DW-1:0] r_div_cnt;
    logic [BW-1:0] r_bit_cnt;
    logic          r_bclk;
    logic          r_lrck;
    logic          w_wrap;
    logic          w_fall;
    logic [BW-1:0] w_bit_nxt;

    assign w_wrap    = (r_div_cnt == DIV_LAST);
    assign w_fall    = w_wrap & r_bclk;
    assign w_bit_nxt = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_bclk    <= 1'b0;
            r_lrck    <= 1'b0;
        end else begin
            r_div_cnt <= w_wrap ? '0 : r_div_cnt + 1'b1;
            if (w_wrap)
                r_bclk <= ~r_bclk;
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_lrck    <= (w_bit_nxt >= SLOT_LEN);
            end
        end
    end

    assign o_bclk        = r_bclk;
    assign o_lrck        = r_lrck;
    assign o_fall_stb    = w_fall;
    assign o_frame_start = w_fall & (r_bit_cnt == BIT_LAST);
    assign o_bit_nxt     = w_bit_nxt;

endmodule

// File: rtl/anc_audio_tx.sv
// I2S transmitter for the anti-noise sample: one-deep holding buffer, frame load and
// serialisation of the same sample into the left and right slots.
module anc_audio_tx
    import anc_audio_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = I2S_CLK_DIV,
    parameter int unsigned DATA_W  = AUDIO_DATA_W,
    parameter int unsigned SLOT_W  = I2S_SLOT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              dac_bclk,
    output logic              dac_lrck,
    output logic              dac_data,
    output logic              audio_tx_down,
    output logic              underrun
);

    localparam int unsigned BW = $clog2(2*SLOT_W);
    localparam int unsigned IW = $clog2(DATA_W);
    localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_W);

    logic              w_fall_stb;
    logic              w_frame_start;
    logic [BW-1:0]     w_bit_nxt;
    logic [BW-1:0]     w_slot_bit;
    logic              w_bit_val;
    logic              w_accept;
    logic              r_buf_full;
    logic [DATA_W-1:0] r_buffer;
    logic [DATA_W-1:0] r_shifter;
    logic              r_data;

    anc_i2s_clkgen #(
        .CLK_DIV (CLK_DIV),
        .SLOT_W  (SLOT_W)
    ) u_clkgen (
        .clk           (clk),
        .rst_n         (rst_n),
        .o_bclk        (dac_bclk),
        .o_lrck        (dac_lrck),
        .o_fall_stb    (w_fall_stb),
        .o_frame_start (w_frame_start),
        .o_bit_nxt     (w_bit_nxt)
    );

    // dac_data is registered on the falling edge, so it is selected from the bit index
    // the counter is about to take; slot bit 0 is the I2S one-bit delay and stays 0.
    assign w_slot_bit = (w_bit_nxt >= SLOT_LEN) ? w_bit_nxt - SLOT_LEN : w_bit_nxt;

    always_comb begin
        w_bit_val = 1'b0;
        for (int unsigned i = 1; i <= DATA_W; i++) begin
            if (w_slot_bit == BW'(i))
                w_bit_val = r_shifter[IW'(DATA_W - i)];
        end
    end

    assign w_accept = tx_valid & ~r_buf_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_full <= 1'b0;
            r_buffer   <= '0;
            r_shifter  <= '0;
            r_data     <= 1'b0;
        end else begin
            // On an empty-buffer frame start the shifter keeps its sample (repeat).
            if (w_frame_start && r_buf_full) begin
                r_shifter  <= r_buffer;
                r_buf_full <= 1'b0;
            end else if (w_accept) begin
                r_buffer   <= tx_data;
                r_buf_full <= 1'b1;
            end
            if (w_fall_stb)
                r_data <= w_bit_val;
        end
    end

    assign tx_ready      = ~r_buf_full;
    assign dac_data      = r_data;
    assign audio_tx_down = w_frame_start & r_buf_full;
    assign underrun      = w_frame_start & ~r_buf_full;

endmodule

// File: tb/tb_anc_audio_tx.sv
// Bench for anc_audio_tx with CLK_DIV=2: time-indexed reference model plus scenario tasks.
module tb_anc_audio_tx;

    localparam int unsigned CD    = 2;
    localparam int unsigned DW    = 16;
    localparam int unsigned SW    = 32;
    localparam int unsigned BITP  = 2*CD;
    localparam int unsigned FRAME = 2*SW*BITP;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic [DW-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, dac_bclk, dac_lrck, dac_data, audio_tx_down, underrun;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Reference model: time since reset release plus the buffer/current-sample contents.
    int unsigned   m_t;
    logic          m_full;
    logic [DW-1:0] m_buf;
    logic [DW-1:0] m_cur;

    logic [5:0]    got;
    logic [5:0]    exp;

    int unsigned   cap_fr;
    logic [DW-1:0] capL;
    logic [DW-1:0] capR;
    int unsigned   cap_tail;

    always #5 clk = ~clk;

    anc_audio_tx #(
        .CLK_DIV (CD),
        .DATA_W  (DW),
        .SLOT_W  (SW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .dac_bclk      (dac_bclk),
        .dac_lrck      (dac_lrck),
        .dac_data      (dac_data),
        .audio_tx_down (audio_tx_down),
        .underrun      (underrun)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t    <= 0;
            m_full <= 1'b0;
            m_buf  <= '0;
            m_cur  <= '0;
        end else begin
            if (((m_t + 1) % FRAME) == 0 && m_full) begin
                m_cur  <= m_buf;
                m_full <= 1'b0;
            end else if (tx_valid && !m_full) begin
                m_buf  <= tx_data;
                m_full <= 1'b1;
            end
            m_t <= m_t + 1;
        end
    end

    // {bclk, lrck, data, ready, tx_down, underrun} expected after m_t clock edges.
    function automatic logic [5:0] f_exp();
        int unsigned   bitn;
        int unsigned   b;
        logic          d;
        logic          fs;
        logic [DW-1:0] sh;
        bitn = (m_t / BITP) % (2*SW);
        b    = bitn % SW;
        d    = 1'b0;
        if (b >= 1 && b <= DW) begin
            sh = m_cur >> (DW - b);
            d  = sh[0];
        end
        fs = ((m_t + 1) % FRAME) == 0;
        return {((m_t / CD) % 2) == 1, bitn >= SW, d, !m_full, fs && m_full, fs && !m_full};
    endfunction

    task automatic tick();
        @(negedge clk);
        got = {dac_bclk, dac_lrck, dac_data, tx_ready, audio_tx_down, underrun};
        exp = f_exp();
    endtask

    task automatic wait_phase(input int unsigned ph);
        for (int i = 0; i < 2*FRAME && (m_t % FRAME) != ph; i++)
            tick();
    endtask

    task automatic cap_clear(input int unsigned fr);
        cap_fr   = fr;
        capL     = '0;
        capR     = '0;
        cap_tail = 0;
    endtask

    task automatic do_capture();
        int unsigned bitn;
        int unsigned b;
        if ((m_t % BITP) == 2 && (m_t / FRAME) == cap_fr) begin
            bitn = (m_t / BITP) % (2*SW);
            b    = bitn % SW;
            if (b >= 1 && b <= DW) begin
                if (bitn >= SW) capR = capR | (DW'(dac_data) << (DW - b));
                else            capL = capL | (DW'(dac_data) << (DW - b));
            end else if (dac_data) begin
                cap_tail++;
            end
        end
    endtask

    task automatic test_reset();
        int unsigned rises = 0, lr_hi = 0, unds = 0, ones = 0;
        logic pb;
        @(negedge clk);
        rst_n = 1'b0;
        tx_valid = 1'b0;
        #1;
        n_chk++;
        if ({dac_bclk, dac_lrck, dac_data, tx_ready, audio_tx_down, underrun} !== 6'b000100)
            $display("FAIL reset_values got %b exp %b",
                     {dac_bclk, dac_lrck, dac_data, tx_ready, audio_tx_down, underrun}, 6'b000100);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        got = {dac_bclk, dac_lrck, dac_data, tx_ready, audio_tx_down, underrun};
        exp = f_exp();
        n_chk++;
        if (got !== exp) $display("FAIL release_t0 got %b exp %b", got, exp); else n_pass++;
        pb = dac_bclk;
        for (int i = 1; i < 256; i++) begin
            tick();
            n_chk++;
            if (got !== exp) $display("FAIL first_frame t=%0d got %b exp %b", m_t, got, exp);
            else n_pass++;
            if (dac_bclk && !pb) rises++;
            pb = dac_bclk;
            if (dac_lrck) lr_hi++;
            if (i < 255 && underrun) unds++;
            if (dac_data) ones++;
        end
        n_chk++; if (rises != 64)  $display("FAIL bclk_rises got %0d exp 64", rises);   else n_pass++;
        n_chk++; if (lr_hi != 128) $display("FAIL lrck_high got %0d exp 128", lr_hi);   else n_pass++;
        n_chk++; if (unds != 0)    $display("FAIL first_underrun got %0d exp 0", unds); else n_pass++;
        n_chk++; if (ones != 0)    $display("FAIL first_data got %0d exp 0", ones);     else n_pass++;
    endtask

    task automatic test_single();
        int unsigned fa, downs = 0;
        wait_phase(100);
        tx_data  = 16'hA5C3;
        tx_valid = 1'b1;
        tick();
        n_chk++; if (got !== exp) $display("FAIL single_accept got %b exp %b", got, exp); else n_pass++;
        tx_valid = 1'b0;
        fa = m_t / FRAME + 1;
        cap_clear(fa);
        for (int i = 0; i < 3*FRAME && m_t != (fa + 1)*FRAME - 2; i++) begin
            tick();
            n_chk++;
            if (got !== exp) $display("FAIL single t=%0d got %b exp %b", m_t, got, exp);
            else n_pass++;
            do_capture();
            if (audio_tx_down) downs++;
        end
        n_chk++; if (downs != 1)      $display("FAIL single_down got %0d exp 1", downs);     else n_pass++;
        n_chk++; if (capL !== 16'hA5C3) $display("FAIL single_left got %h exp a5c3", capL);  else n_pass++;
        n_chk++; if (capR !== 16'hA5C3) $display("FAIL single_right got %h exp a5c3", capR); else n_pass++;
        n_chk++; if (cap_tail != 0)   $display("FAIL single_tail got %0d exp 0", cap_tail);  else n_pass++;
    endtask

    task automatic test_repeat();
        int unsigned fa, downs = 0, unds = 0;
        fa = m_t / FRAME + 1;
        cap_clear(fa);
        for (int i = 0; i < 3*FRAME && m_t != (fa + 1)*FRAME - 2; i++) begin
            tick();
            n_chk++;
            if (got !== exp) $display("FAIL repeat t=%0d got %b exp %b", m_t, got, exp);
            else n_pass++;
            do_capture();
            if (audio_tx_down) downs++;
            if (underrun) unds++;
        end
        n_chk++; if (unds != 1)  $display("FAIL repeat_underrun got %0d exp 1", unds); else n_pass++;
        n_chk++; if (downs != 0) $display("FAIL repeat_down got %0d exp 0", downs);    else n_pass++;
        n_chk++; if (capL !== 16'hA5C3) $display("FAIL repeat_left got %h exp a5c3", capL);  else n_pass++;
        n_chk++; if (capR !== 16'hA5C3) $display("FAIL repeat_right got %h exp a5c3", capR); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int unsigned acc_t = 0, k, downs = 0;
        wait_phase(50);
        tx_data  = 16'd1;
        tx_valid = 1'b1;
        tick();
        n_chk++; if (got !== exp) $display("FAIL b2b_first t=%0d got %b exp %b", m_t, got, exp); else n_pass++;
        tx_data = 16'd2;
        n_chk++; if (tx_ready !== 1'b0) $display("FAIL b2b_ready_low got %b exp 0", tx_ready); else n_pass++;
        for (int i = 0; i < 2*FRAME && acc_t == 0; i++) begin
            if (tx_ready) acc_t = m_t + 1;
            tick();
            n_chk++;
            if (got !== exp) $display("FAIL b2b_hold t=%0d got %b exp %b", m_t, got, exp);
            else n_pass++;
        end
        tx_valid = 1'b0;
        n_chk++;
        if ((acc_t % FRAME) != 1) $display("FAIL b2b_accept_phase got %0d exp 1", acc_t % FRAME);
        else n_pass++;
        k = acc_t / FRAME;
        for (int f = 0; f < 2; f++) begin
            cap_clear(k + f);
            for (int i = 0; i < 3*FRAME && m_t != (k + f + 1)*FRAME - 2; i++) begin
                tick();
                n_chk++;
                if (got !== exp) $display("FAIL b2b_frame t=%0d got %b exp %b", m_t, got, exp);
                else n_pass++;
                do_capture();
                if (audio_tx_down) downs++;
            end
            n_chk++;
            if (capL !== DW'(f + 1)) $display("FAIL b2b_sample%0d got %h exp %h", f + 1, capL, DW'(f + 1));
            else n_pass++;
        end
        n_chk++; if (downs != 1) $display("FAIL b2b_down got %0d exp 1", downs); else n_pass++;
    endtask

    task automatic test_8000();
        int unsigned fa, downs = 0;
        wait_phase(30);
        tx_data  = 16'h8000;
        tx_valid = 1'b1;
        tick();
        n_chk++; if (got !== exp) $display("FAIL min_accept got %b exp %b", got, exp); else n_pass++;
        tx_valid = 1'b0;
        fa = m_t / FRAME + 1;
        cap_clear(fa);
        for (int i = 0; i < 3*FRAME && m_t != (fa + 1)*FRAME - 2; i++) begin
            tick();
            n_chk++;
            if (got !== exp) $display("FAIL min t=%0d got %b exp %b", m_t, got, exp);
            else n_pass++;
            do_capture();
            if (audio_tx_down) downs++;
        end
        n_chk++; if (capL !== 16'h8000) $display("FAIL min_left got %h exp 8000", capL);  else n_pass++;
        n_chk++; if (capR !== 16'h8000) $display("FAIL min_right got %h exp 8000", capR); else n_pass++;
        n_chk++; if (downs != 1) $display("FAIL min_down got %0d exp 1", downs); else n_pass++;
    endtask

    task automatic test_random();
        logic acc_now;
        for (int i = 0; i < 4*FRAME; i++) begin
            acc_now = tx_valid && tx_ready;
            tick();
            n_chk++;
            if (got !== exp) $display("FAIL random t=%0d got %b exp %b", m_t, got, exp);
            else n_pass++;
            if (acc_now) tx_valid = 1'b0;
            if (!tx_valid && $urandom_range(0, 199) == 0) begin
                tx_valid = 1'b1;
                tx_data  = DW'($urandom);
            end
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_midreset();
        int unsigned downs = 0, unds = 0, ones = 0;
        wait_phase(5);
        tx_data  = DW'($urandom) | 16'h0100;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        wait_phase((SW + 10)*BITP + 1);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({dac_bclk, dac_lrck, dac_data, tx_ready, audio_tx_down, underrun} !== 6'b000100)
            $display("FAIL midreset_values got %b exp %b",
                     {dac_bclk, dac_lrck, dac_data, tx_ready, audio_tx_down, underrun}, 6'b000100);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i < 256; i++) begin
            tick();
            n_chk++;
            if (got !== exp) $display("FAIL midreset_frame t=%0d got %b exp %b", m_t, got, exp);
            else n_pass++;
            if (audio_tx_down) downs++;
            if (underrun) unds++;
            if (dac_data) ones++;
        end
        n_chk++; if (downs != 0) $display("FAIL midreset_down got %0d exp 0", downs);    else n_pass++;
        n_chk++; if (unds != 1)  $display("FAIL midreset_underrun got %0d exp 1", unds); else n_pass++;
        n_chk++; if (ones != 0)  $display("FAIL midreset_data got %0d exp 0", ones);     else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_back_to_back();
        test_8000();
        test_random();
        test_midreset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at t=%0d", m_t);
        $fatal(1, "watchdog");
    end

endmodule
